// File: rtl/tow_vga_pkg.sv
// ---------------------------------------------------------------------------
// tow_vga_pkg
// Shared constants for the tug-of-war VGA path: 8-bit RGB colours
// ({R[2:0],G[2:0],B[1:0]}), visible screen geometry, winner encodings and
// the rope-position clamp helper used by the frame latch.
// ---------------------------------------------------------------------------
package tow_vga_pkg;

  localparam logic [7:0] COL_BLACK  = 8'h00;
  localparam logic [7:0] COL_WHITE  = 8'hFF;
  localparam logic [7:0] COL_RED    = 8'hE0;
  localparam logic [7:0] COL_BLUE   = 8'h03;
  localparam logic [7:0] COL_ROPE   = 8'hA8;
  localparam logic [7:0] COL_CENTER = 8'h1C;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam logic [9:0] CENTER_X = 10'd320;

  // Latched marker position limits: keep the 8-px marker fully on screen.
  localparam logic [9:0] POS_MIN = 10'd4;
  localparam logic [9:0] POS_MAX = 10'd635;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_LEFT  = 2'b01,
    WIN_RIGHT = 2'b10,
    WIN_BOTH  = 2'b11  // not a legal game result; rendered as no winner
  } winner_e;

  function automatic logic [9:0] clamp_pos(input logic [9:0] p);
    if (p < POS_MIN)      clamp_pos = POS_MIN;
    else if (p > POS_MAX) clamp_pos = POS_MAX;
    else                  clamp_pos = p;
  endfunction

endpackage

// File: rtl/tow_frame_latch.sv
// ---------------------------------------------------------------------------
// tow_frame_latch
// Detects the start of vertical blanking (sampled vOutValid falling on a
// pixel strobe) and, on that event, latches the clamped rope position and
// the winner, advances the 4-bit blink counter and pulses frame_tick for one
// clk on the following clock. Game inputs therefore change only once per
// frame, during blanking.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   pixel_en      pixel-rate enable
//   v_out_valid   vertical visible flag from the timing counter
//   rope_pos      marker centre x from game logic (unclamped)
//   winner        00 none, 01 left, 10 right, 11 treated as none
//   pos_q         latched, clamped marker centre (reset 320)
//   win_q         latched winner, never 11 (reset 00)
//   blink_cnt     frame counter, wraps 15 -> 0
//   frame_tick    one-clk pulse after each frame event
// ---------------------------------------------------------------------------
module tow_frame_latch
  import tow_vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pixel_en,
  input  logic       v_out_valid,
  input  logic [9:0] rope_pos,
  input  logic [1:0] winner,
  output logic [9:0] pos_q,
  output logic [1:0] win_q,
  output logic [3:0] blink_cnt,
  output logic       frame_tick
);

  logic prev_v;
  logic frame_evt;

  // Previous sample is registered, current one is the live input, so the
  // event coincides with the first blanking strobe.
  assign frame_evt = pixel_en & prev_v & ~v_out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_v     <= 1'b1;
      pos_q      <= CENTER_X;
      win_q      <= WIN_NONE;
      blink_cnt  <= 4'd0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_evt;
      if (pixel_en) prev_v <= v_out_valid;
      if (frame_evt) begin
        pos_q     <= clamp_pos(rope_pos);
        win_q     <= (winner == WIN_BOTH) ? WIN_NONE : winner;
        blink_cnt <= blink_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/tow_pixel_renderer.sv
// ---------------------------------------------------------------------------
// tow_pixel_renderer
// Two-stage pixel renderer for the tug-of-war display. Stage 1 registers the
// visibility flag, syncs and region hits (rope band, marker, goal lines);
// stage 2 resolves colour priority into rgb and delays the syncs to match.
// Both stages advance only on pixel_en. Game state comes from
// tow_frame_latch, so the picture is stable for a whole frame.
//
// Optional feature: define TOW_CENTER_LINE_EN to draw a 1-px centre line at
// x = 320 (colour 0x1C), ranked just below the goal lines.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pixel_en                 pixel-rate enable
//   horiz_pixel_count        current x
//   vert_pixel_count         current y
//   hSync_in, vSync_in       active-low syncs from the timing counter
//   hOutValid, vOutValid     visible-region flags
//   rope_pos                 marker centre x from game logic
//   winner                   00 none, 01 left, 10 right, 11 as 00
//   rgb                      {R[2:0],G[2:0],B[1:0]}, 2 strobes latency
//   hSync, vSync             syncs delayed to align with rgb
//   frame_tick               one-clk pulse at start of vertical blanking
// ---------------------------------------------------------------------------
module tow_pixel_renderer
  import tow_vga_pkg::*;
#(
  parameter int ROPE_Y0   = 232,
  parameter int MARK_HALF = 4,
  parameter int GOAL_L    = 80,
  parameter int GOAL_R    = 558
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixel_en,
  input  logic [9:0] horiz_pixel_count,
  input  logic [9:0] vert_pixel_count,
  input  logic       hSync_in,
  input  logic       vSync_in,
  input  logic       hOutValid,
  input  logic       vOutValid,
  input  logic [9:0] rope_pos,
  input  logic [1:0] winner,
  output logic [7:0] rgb,
  output logic       hSync,
  output logic       vSync,
  output logic       frame_tick
);

  logic [9:0] pos_q;
  logic [1:0] win_q;
  logic [3:0] blink_cnt;

  tow_frame_latch u_frame_latch (
    .clk         (clk),
    .rst         (rst),
    .pixel_en    (pixel_en),
    .v_out_valid (vOutValid),
    .rope_pos    (rope_pos),
    .winner      (winner),
    .pos_q       (pos_q),
    .win_q       (win_q),
    .blink_cnt   (blink_cnt),
    .frame_tick  (frame_tick)
  );

  // ---------------- region hits (combinational, stage-1 inputs) ----------
  // 11-bit arithmetic keeps pos +/- MARK_HALF free of wrap-around.
  logic [10:0] x_w, y_w, mark_lo, mark_hi;
  logic        hit_band, hit_mark, hit_goal_l, hit_goal_r, hit_center;

  always_comb begin
    x_w        = {1'b0, horiz_pixel_count};
    y_w        = {1'b0, vert_pixel_count};
    mark_lo    = {1'b0, pos_q} - 11'(MARK_HALF);
    mark_hi    = {1'b0, pos_q} + 11'(MARK_HALF - 1);
    hit_band   = (y_w >= 11'(ROPE_Y0)) && (y_w <= 11'(ROPE_Y0 + 15));
    // The marker sits on the rope, so it shares the band's rows.
    hit_mark   = hit_band && (x_w >= mark_lo) && (x_w <= mark_hi);
    hit_goal_l = (x_w == 11'(GOAL_L)) || (x_w == 11'(GOAL_L + 1));
    hit_goal_r = (x_w == 11'(GOAL_R)) || (x_w == 11'(GOAL_R + 1));
`ifdef TOW_CENTER_LINE_EN
    hit_center = (horiz_pixel_count == CENTER_X);
`else
    hit_center = 1'b0;
`endif
  end

  // ---------------- stage 1 ----------------------------------------------
  // Coordinates are reduced to hit flags here, so stage 2 needs only flags.
  logic s1_vis, s1_hs, s1_vs;
  logic s1_band, s1_mark, s1_goal_l, s1_goal_r, s1_center;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vis    <= 1'b0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
      s1_band   <= 1'b0;
      s1_mark   <= 1'b0;
      s1_goal_l <= 1'b0;
      s1_goal_r <= 1'b0;
      s1_center <= 1'b0;
    end else if (pixel_en) begin
      s1_vis    <= hOutValid & vOutValid;
      s1_hs     <= hSync_in;
      s1_vs     <= vSync_in;
      s1_band   <= hit_band;
      s1_mark   <= hit_mark;
      s1_goal_l <= hit_goal_l;
      s1_goal_r <= hit_goal_r;
      s1_center <= hit_center;
    end
  end

  // ---------------- stage 2: priority mux --------------------------------
  logic       flash;
  logic [7:0] rgb_next;

  always_comb begin
    flash    = (win_q != WIN_NONE) && blink_cnt[3];
    rgb_next = COL_BLACK;
    if (!s1_vis)        rgb_next = COL_BLACK;
    else if (s1_mark)   rgb_next = COL_WHITE;
    else if (s1_goal_l) rgb_next = COL_RED;
    else if (s1_goal_r) rgb_next = COL_BLUE;
    else if (s1_center) rgb_next = COL_CENTER;
    else if (s1_band)   rgb_next = COL_ROPE;
    else if (flash)     rgb_next = (win_q == WIN_LEFT) ? COL_RED : COL_BLUE;
    else                rgb_next = COL_BLACK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb   <= COL_BLACK;
      hSync <= 1'b1;
      vSync <= 1'b1;
    end else if (pixel_en) begin
      rgb   <= rgb_next;
      hSync <= s1_hs;
      vSync <= s1_vs;
    end
  end

endmodule

// File: tb/tb_tow_pixel_renderer.sv
// ---------------------------------------------------------------------------
// tb_tow_pixel_renderer
// Directed vectors with hand-computed colours. Each pixel strobe pushes its
// expected {rgb, hSync, vSync} into exp_q; a monitor pops and compares the
// DUT output two strobes later. Frame events, frame_tick pulses, freeze and
// asynchronous reset are checked alongside.
// ---------------------------------------------------------------------------
module tb_tow_pixel_renderer;

  // ---------------- clock / reset ----------------------------------------
  logic       clk;
  logic       rst;
  logic       pixel_en;
  logic [9:0] horiz_pixel_count;
  logic [9:0] vert_pixel_count;
  logic       hSync_in, vSync_in;
  logic       hOutValid, vOutValid;
  logic [9:0] rope_pos;
  logic [1:0] winner;
  logic [7:0] rgb;
  logic       hSync, vSync;
  logic       frame_tick;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tow_pixel_renderer dut (
    .clk               (clk),
    .rst               (rst),
    .pixel_en          (pixel_en),
    .horiz_pixel_count (horiz_pixel_count),
    .vert_pixel_count  (vert_pixel_count),
    .hSync_in          (hSync_in),
    .vSync_in          (vSync_in),
    .hOutValid         (hOutValid),
    .vOutValid         (vOutValid),
    .rope_pos          (rope_pos),
    .winner            (winner),
    .rgb               (rgb),
    .hSync             (hSync),
    .vSync             (vSync),
    .frame_tick        (frame_tick)
  );

  // ---------------- scoreboard state -------------------------------------
  logic [9:0] exp_q[$];
  logic [9:0] last_out;
  int         n_checks;
  int         n_fail;
  int         mon_sz;
  int         tick_cnt;
  int         exp_ticks;
  logic       prev_tick;
  logic [7:0] c_line;   // x = 320 off the band and off the marker
  logic [7:0] c_band;   // x = 320 on the band, marker elsewhere

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks -----------------------------------------
  // Called just after a rising edge; presents one pixel for one strobe.
  task automatic pix(input int x, input int y, input logic hv, input logic vv,
                     input logic hs, input logic vs, input logic [7:0] exp);
    pixel_en          = 1'b1;
    horiz_pixel_count = 10'(x);
    vert_pixel_count  = 10'(y);
    hOutValid         = hv;
    vOutValid         = vv;
    hSync_in          = hs;
    vSync_in          = vs;
    exp_q.push_back({exp, hs, vs});
    @(posedge clk);
    #1;
  endtask

  task automatic vis(input int x, input int y, input logic [7:0] exp);
    pix(x, y, 1'b1, 1'b1, 1'b1, 1'b1, exp);
  endtask

  // Last visible-line pixel, then the first blanking strobe; pos is applied
  // on the event clock itself so the same-clock latch is exercised.
  task automatic frame_event(input logic [9:0] pos);
    pix(639, 479, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    rope_pos = pos;
    pix(0, 480, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    exp_ticks++;
    check("frame_tick_pulse", {31'b0, frame_tick}, 32'd1);
  endtask

  // ---------------- monitors ---------------------------------------------
  always @(posedge clk) begin
    if (!rst && pixel_en) begin
      mon_sz = exp_q.size();
      #1;
      if (mon_sz >= 2) begin
        last_out = exp_q.pop_front();
        check("pix_out", {22'b0, rgb, hSync, vSync}, {22'b0, last_out});
      end
    end
  end

  always @(negedge clk) begin
    if (frame_tick === 1'b1) begin
      tick_cnt++;
      check("tick_width", {31'b0, prev_tick}, 32'd0);
    end
    prev_tick = frame_tick;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ---------------------------------------------
  initial begin
    n_checks = 0; n_fail = 0; tick_cnt = 0; exp_ticks = 0; prev_tick = 1'b0;
    last_out = '0; mon_sz = 0;
`ifdef TOW_CENTER_LINE_EN
    c_line = 8'h1C; c_band = 8'h1C;
`else
    c_line = 8'h00; c_band = 8'hA8;
`endif
    rst = 1'b1; pixel_en = 1'b0;
    horiz_pixel_count = '0; vert_pixel_count = '0;
    hSync_in = 1'b1; vSync_in = 1'b1; hOutValid = 1'b0; vOutValid = 1'b1;
    rope_pos = 10'd320; winner = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb",   {24'b0, rgb}, 32'h00);
    check("reset_hsync", {31'b0, hSync}, 32'd1);
    check("reset_vsync", {31'b0, vSync}, 32'd1);
    check("reset_tick",  {31'b0, frame_tick}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Default frame, pos 320, no winner.
    vis(320, 240, 8'hFF);
    vis(100, 240, 8'hA8);
    vis(80, 10, 8'hE0);
    vis(81, 10, 8'hE0);
    vis(559, 10, 8'h03);
    vis(558, 10, 8'h03);
    pix(700, 240, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    pix(316, 240, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
    vis(315, 240, 8'hA8);
    vis(323, 240, 8'hFF);
    vis(324, 240, 8'hA8);
    vis(320, 100, c_line);
    vis(320, 248, c_line);
    vis(100, 232, 8'hA8);
    vis(100, 247, 8'hA8);
    vis(100, 248, 8'h00);
    vis(319, 100, 8'h00);

    // Mid-frame position change: no effect until the next event.
    rope_pos = 10'd400;
    vis(320, 240, 8'hFF);
    vis(400, 240, 8'hA8);
    frame_event(10'd400);
    vis(400, 240, 8'hFF);
    vis(396, 240, 8'hFF);
    vis(395, 240, 8'hA8);
    vis(403, 240, 8'hFF);
    vis(404, 240, 8'hA8);
    vis(320, 240, c_band);

    // Clamp low / high.
    frame_event(10'd0);
    vis(0, 240, 8'hFF);
    vis(7, 240, 8'hFF);
    vis(8, 240, 8'hA8);
    rope_pos = 10'd500;
    frame_event(10'd1023);
    rope_pos = 10'd10;
    vis(631, 240, 8'hFF);
    vis(638, 240, 8'hFF);
    vis(630, 240, 8'hA8);
    vis(639, 240, 8'hA8);

    // Freeze: pixel_en low for 5 clocks with inputs wiggling.
    pix(320, 240, 1'b1, 1'b1, 1'b0, 1'b0, c_band);
    pix(631, 240, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
    pixel_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      horiz_pixel_count = 10'(i * 7);
      hSync_in = i[0];
      vSync_in = ~i[0];
      hOutValid = i[0];
      @(posedge clk);
      #1;
      check("freeze", {22'b0, rgb, hSync, vSync}, {22'b0, last_out});
    end
    vis(100, 240, 8'hA8);
    vis(100, 10, 8'h00);

    // Asynchronous reset mid-line (outputs currently non-reset values).
    pix(631, 240, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
    pix(632, 240, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
    pixel_en = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("async_rst_rgb",   {24'b0, rgb}, 32'h00);
    check("async_rst_hsync", {31'b0, hSync}, 32'd1);
    check("async_rst_vsync", {31'b0, vSync}, 32'd1);
    exp_q.delete();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    rope_pos = 10'd500;
    vis(320, 240, 8'hFF);
    vis(316, 240, 8'hFF);
    vis(324, 240, 8'hA8);
    vis(500, 240, 8'hA8);

    // Left winner for 16 frames: flash on events 8..15.
    winner = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      frame_event(10'd320);
      vis(50, 100, (k >= 8 && k <= 15) ? 8'hE0 : 8'h00);
      vis(50, 240, 8'hA8);
    end

    // Winner 11 renders as none even with blink bit 3 set.
    winner = 2'b11;
    for (int k = 1; k <= 8; k++) frame_event(10'd320);
    vis(50, 100, 8'h00);
    winner = 2'b10;
    frame_event(10'd320);
    vis(50, 100, 8'h03);
    vis(81, 100, 8'hE0);
    winner = 2'b01;
    vis(50, 100, 8'h03);

    // Drain the pipeline.
    pix(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    pix(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    @(negedge clk);
    check("tick_count", tick_cnt, exp_ticks);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tow_pixel_renderer.md
# tow_pixel_renderer

Pixel renderer for the tug-of-war display, directly downstream of the VGA timing counter. Consumes the counter's pixel coordinates, valid flags and sync signals plus the rope position and winner from game logic, and produces 8-bit RGB with sync delayed to match. Game inputs are latched once per frame at the start of vertical blanking, so the picture never tears.

## Interface
Parameters:
- `ROPE_Y0`, default 232: first row of the rope band, which is 16 rows tall (232..247).
- `MARK_HALF`, default 4: marker half-width; marker spans x = pos-4 .. pos+3.
- `GOAL_L`, default 80: left goal line x (2 px wide, 80..81).
- `GOAL_R`, default 558: right goal line x (2 px wide, 558..559).

Ports:
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous active-high reset
- `pixel_en`  in  1  pixel-rate enable; all pipeline advances are qualified by it
- `horiz_pixel_count`  in  10  current x coordinate
- `vert_pixel_count`  in  10  current y coordinate
- `hSync_in`, `vSync_in`  in  1 each  syncs from the timing counter (active low)
- `hOutValid`, `vOutValid`  in  1 each  visible-region flags
- `rope_pos`  in  10  marker centre x from game logic
- `winner`  in  2  00 none, 01 left, 10 right, 11 treated as 00
- `rgb`  out  8  {R[2:0],G[2:0],B[1:0]}
- `hSync`, `vSync`  out  1 each  delayed syncs
- `frame_tick`  out  1  one-`clk` pulse at the start of vertical blanking

## Operation
- Stage 1, on `pixel_en`: register the coordinates, the valid AND, the syncs, and the region hits.
  - Region hits: rope band, marker, left goal line, right goal line, computed against the latched position.
- Stage 2, on `pixel_en`: priority mux, registered into `rgb`. Syncs are delayed through the same stages.
- Priority, highest first:
  - invisible -> 0x00
  - marker -> 0xFF
  - left goal line -> 0xE0
  - right goal line -> 0x03
  - rope band -> 0xA8
  - flash background -> 0xE0 for left winner, 0x03 for right winner
  - otherwise black 0x00
- Frame event: detected when `pixel_en` is high and the sampled `vOutValid` falls (registered previous value 1, current 0).
  - On the event: latch `rope_pos` (clamped) and `winner`, increment the 4-bit `blink_cnt`, and pulse `frame_tick` on the next clock.
- Clamp: `rope_pos` < 4 latches as 4; `rope_pos` > 635 latches as 635.
- Flash is active when the latched winner is non-zero and `blink_cnt[3]` = 1, i.e. it toggles every 8 frames.
- `rope_pos` or `winner` changes between frame events have no visible effect until the next event.

## Timing
- Latency: exactly 2 `pixel_en` strobes from inputs to `rgb`, `hSync` and `vSync`. Sync-to-colour alignment is preserved.
- When `pixel_en` is low, all pipeline registers hold.
- `frame_tick` is high for exactly one `clk`, registered one `clk` after the detecting edge.
- Reset values (asynchronous; apply mid-frame too):
  - `rgb` = 0, `hSync` = 1, `vSync` = 1, `frame_tick` = 0
  - latched position = 320, latched winner = 00
  - `blink_cnt` = 0, previous-`vOutValid` register = 1
- After reset release, the first valid output appears on the 2nd `pixel_en` strobe.
- `blink_cnt` wraps from 15 to 0.
- If a frame event and a `rope_pos` change occur on the same clock, the value present on that clock is the one latched.

## Configuration
- Macro `TOW_CENTER_LINE_EN`.
- Defined: a 1-px centre line at x = 320, colour 0x1C, with priority just below the goal lines (above the rope band).
- Undefined: no centre line; x = 320 renders as the rest of the priority list dictates.

## Structure
- Shared package `tow_vga_pkg` holds:
  - colour constants: COL_BLACK, COL_WHITE, COL_RED, COL_BLUE, COL_ROPE, COL_CENTER
  - screen constants: H_VISIBLE = 640, V_VISIBLE = 480, centre X = 320
  - winner encodings
- One sub-module, `tow_frame_latch`, owns the `vOutValid` fall detect, the clamp, the position/winner latches, `blink_cnt` and `frame_tick`.
- The renderer top owns the two pipeline stages and the mux.

## Test plan
- Reset, then run a full 800x525 frame with `rope_pos` = 320 and winner 00:
  - pixel (320, 240) -> 0xFF
  - pixel (100, 240) -> 0xA8
  - pixel (80, 10) -> 0xE0
  - pixel (559, 10) -> 0x03
  - pixel (700, 240) -> 0x00
  - each appears 2 strobes after its input.
- Change `rope_pos` from 320 to 400 mid-frame -> the marker stays at 316..323 for the rest of that frame; 396..403 from the next frame.
- `rope_pos` = 0 -> latched 4; marker at x 0..7. `rope_pos` = 1023 -> latched 635; marker at 631..638.
- Winner 01 held for 16 frames -> background 0x00 for frame events 1-7, 0xE0 for events 8-15 (visible pixels outside other regions); `frame_tick` gives 16 single-clock pulses.
- Assert `rst` mid-line -> `rgb` = 0 and `hSync` = `vSync` = 1 immediately, with no wait for a clock. After release, the latched position renders at 320.
- Hold `pixel_en` low for 5 clocks mid-line -> outputs frozen. With `TOW_CENTER_LINE_EN` defined, (320, 100) -> 0x1C.
